sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser.sv | 105 ++++++++++
 tb/tb_sipo_deser.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer.
// LSB-first word assembly feeding a small output FIFO.
module sipo_deser #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ser_valid_i,
  input  logic             ser_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             frame_err_o,
  output logic             ovf_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] word;
  logic             last;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign last    = ser_valid_i && (cnt == CW'(WIDTH - 1));
  assign full    = (count == (AW + 1)'(DEPTH));
  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i;
  // A full buffer still accepts when the head leaves on the same edge
  assign push_ok = last && (!full || pop);
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

  // Assembly register with the incoming bit merged at the current index
  always_comb begin
    word      = asm_q;
    word[cnt] = ser_data_i;
  end

  // Frame FSM: bit counter, assembly register and abort detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      asm_q       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= (state == SHIFT) && !ser_valid_i;
      if (ser_valid_i && !last) begin
        state <= SHIFT;
        cnt   <= cnt + 1'b1;
        asm_q <= word;
      end else begin
        state <= IDLE;
        cnt   <= '0;
        asm_q <= '0;
      end
    end
  end

  // Buffer pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop) begin
        count <= count - 1'b1;
      end
      if (last && full && !pop) begin
        ovf_o <= 1'b1;
      end
    end
  end

  // Buffer storage; contents are only visible while occupied
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= word;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed testbench for sipo_deser.
// Each task drives one scenario and checks hand-computed results.
module tb_sipo_deser;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       ser_valid_i = 1'b0;
  logic       ser_data_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [3:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       ovf_o;

  int checks = 0;
  int failures = 0;

  sipo_deser #(.WIDTH(4), .DEPTH(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ser_valid_i (ser_valid_i),
    .ser_data_i  (ser_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bit_in(input logic v, input logic d);
    ser_valid_i = v;
    ser_data_i  = d;
    tick();
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      bit_in(1'b1, w[i]);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    ser_valid_i = 1'b0;
    ready_i = 1'b0;
    #3;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({data_o, valid_o, frame_err_o, ovf_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {data_o, valid_o, frame_err_o, ovf_o});
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] w;
    w = 4'hD;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b1, w[i]);
      checks++;
      if (valid_o !== 1'b0) begin
        failures++;
        $display("FAIL single_early_valid bit=%0d got=%b exp=0", i, valid_o);
      end
    end
    bit_in(1'b1, w[3]);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'hD) begin
      failures++;
      $display("FAIL single_word got v=%b d=%h exp v=1 d=d", valid_o, data_o);
    end
    bit_in(1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
      failures++;
      $display("FAIL single_after got v=%b fe=%b exp v=0 fe=0",
               valid_o, frame_err_o);
    end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b0;
    send_word(4'h3);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'h3) begin
      failures++;
      $display("FAIL b2b_first got v=%b d=%h exp v=1 d=3", valid_o, data_o);
    end
    send_word(4'hA);
    bit_in(1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'h3 || ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold got v=%b d=%h ovf=%b exp v=1 d=3 ovf=0",
               valid_o, data_o, ovf_o);
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'hA) begin
      failures++;
      $display("FAIL b2b_pop1 got v=%b d=%h exp v=1 d=a", valid_o, data_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pop2 got v=%b exp v=0", valid_o);
    end
  endtask

  task automatic test_abort();
    ready_i = 1'b1;
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    checks++;
    if (frame_err_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse got fe=%b v=%b exp fe=1 v=0",
               frame_err_o, valid_o);
    end
    tick();
    checks++;
    if (frame_err_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_end got fe=%b v=%b exp fe=0 v=0",
               frame_err_o, valid_o);
    end
    send_word(4'h5);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'h5) begin
      failures++;
      $display("FAIL abort_next got v=%b d=%h exp v=1 d=5", valid_o, data_o);
    end
    bit_in(1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(4'h1);
    send_word(4'h2);
    send_word(4'h3);
    ser_valid_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 4'h1) begin
      failures++;
      $display("FAIL ovf_set got ovf=%b v=%b d=%h exp ovf=1 v=1 d=1",
               ovf_o, valid_o, data_o);
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'h2) begin
      failures++;
      $display("FAIL ovf_second got v=%b d=%h exp v=1 d=2", valid_o, data_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got v=%b ovf=%b exp v=0 ovf=1",
               valid_o, ovf_o);
    end
    do_reset();
    checks++;
    if (ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got ovf=%b exp 0", ovf_o);
    end
    send_word(4'h1);
    send_word(4'h2);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0);
    ready_i = 1'b1;
    bit_in(1'b1, 1'b0);
    ser_valid_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 4'h2) begin
      failures++;
      $display("FAIL ovf_pushpop got ovf=%b v=%b d=%h exp ovf=0 v=1 d=2",
               ovf_o, valid_o, data_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'h3) begin
      failures++;
      $display("FAIL ovf_third got v=%b d=%h exp v=1 d=3", valid_o, data_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain got v=%b ovf=%b exp v=0 ovf=0",
               valid_o, ovf_o);
    end
  endtask

  task automatic test_reset_midframe();
    ready_i = 1'b0;
    send_word(4'h6);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    ser_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({data_o, valid_o, frame_err_o, ovf_o} !== 7'b0) begin
      failures++;
      $display("FAIL rst_async got=%b exp=0000000",
               {data_o, valid_o, frame_err_o, ovf_o});
    end
    #2;
    rst_i = 1'b0;
    tick();
    checks++;
    if (frame_err_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_err got fe=%b v=%b exp fe=0 v=0",
               frame_err_o, valid_o);
    end
    ready_i = 1'b1;
    send_word(4'h9);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'h9) begin
      failures++;
      $display("FAIL rst_next got v=%b d=%h exp v=1 d=9", valid_o, data_o);
    end
    bit_in(1'b0, 1'b0);
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit_in(1'b0, 1'b1);
      if (frame_err_o !== 1'b0 || valid_o !== 1'b0) begin
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_gap got bad_cycles=%0d exp 0", bad);
    end
    send_word(4'hE);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 4'hE) begin
      failures++;
      $display("FAIL idle_word got v=%b d=%h exp v=1 d=e", valid_o, data_o);
    end
    bit_in(1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_end got v=%b fe=%b exp v=0 fe=0",
               valid_o, frame_err_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_overflow();
    test_reset_midframe();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
